// File: rtl/modexp_ctrl.sv
// Purpose: modular-exponentiation sequencer, x^e mod M by left-to-right square-and-multiply over one external montgomery block.
// Latency: (2 + bits processed + popcount(e)) ops, each 1 issue cycle plus montgomery time; done one cycle after the last capture.
// Backpressure: start is ignored unless idle; every op waits for mont_done low, then accepts the first mont_done high.
// Optional feature: define MODEXP_SKIP_LEADING_ZEROS_EN to add a SCAN state that skips leading zero exponent bits.
module modexp_ctrl #(
    parameter int E_WIDTH = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [1023:0]       in_x,
    input  logic [E_WIDTH-1:0]  in_e,
    input  logic [1023:0]       in_m,
    input  logic [1023:0]       in_r,
    input  logic [1023:0]       in_r2,
    output logic [1023:0]       result,
    output logic                done,
    output logic                busy,
    output logic                mont_start,
    output logic [1023:0]       mont_a,
    output logic [1023:0]       mont_b,
    output logic [1023:0]       mont_m,
    input  logic [1023:0]       mont_result,
    input  logic                mont_done
);

    localparam int            IW  = $clog2(E_WIDTH);
    localparam logic [1023:0] ONE = 1024'd1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TOX,
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
        S_SCAN,
`endif
        S_SQ,
        S_MUL,
        S_FROM,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        PH_ISSUE,
        PH_WAIT_LOW,
        PH_WAIT_HIGH
    } phase_t;

    state_t             state;
    phase_t             phase;
    logic [IW-1:0]      idx;
    logic [E_WIDTH-1:0] e_q;
    logic [1023:0]      a_q;
    logic [1023:0]      xm_q;

    // Sequencer: x and R2 are held in mont_a/mont_b for the TOX op and M in mont_m for the
    // whole run, so only the exponent needs its own copy. Next-op operands are loaded on the
    // same edge the previous result is captured, so mont_start follows the accepting edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            phase      <= PH_ISSUE;
            idx        <= '0;
            e_q        <= '0;
            a_q        <= '0;
            xm_q       <= '0;
            result     <= '0;
            done       <= 1'b0;
            busy       <= 1'b0;
            mont_start <= 1'b0;
            mont_a     <= '0;
            mont_b     <= '0;
            mont_m     <= '0;
        end else begin
            mont_start <= 1'b0;
            done       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        e_q        <= in_e;
                        idx        <= IW'(E_WIDTH - 1);
                        a_q        <= in_r;
                        mont_m     <= in_m;
                        mont_a     <= in_x;
                        mont_b     <= in_r2;
                        mont_start <= 1'b1;
                        busy       <= 1'b1;
                        phase      <= PH_ISSUE;
                        state      <= S_TOX;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
                S_SCAN: begin
                    // One exponent bit per cycle; stop on the first set bit or at bit 0.
                    if (!e_q[idx] && idx != '0) begin
                        idx <= idx - 1'b1;
                    end else if (e_q[idx]) begin
                        mont_a     <= a_q;
                        mont_b     <= a_q;
                        mont_start <= 1'b1;
                        phase      <= PH_ISSUE;
                        state      <= S_SQ;
                    end else begin
                        mont_a     <= a_q;
                        mont_b     <= ONE;
                        mont_start <= 1'b1;
                        phase      <= PH_ISSUE;
                        state      <= S_FROM;
                    end
                end
`endif
                default: begin
                    case (phase)
                        PH_ISSUE: phase <= PH_WAIT_LOW;
                        // A done level still high from the previous op must not be taken as ours.
                        PH_WAIT_LOW: begin
                            if (!mont_done) phase <= PH_WAIT_HIGH;
                        end
                        default: begin
                            if (mont_done) begin
                                phase <= PH_ISSUE;
                                case (state)
                                    S_TOX: begin
                                        xm_q <= mont_result;
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
                                        state <= S_SCAN;
`else
                                        mont_a     <= a_q;
                                        mont_b     <= a_q;
                                        mont_start <= 1'b1;
                                        state      <= S_SQ;
`endif
                                    end
                                    S_SQ: begin
                                        a_q        <= mont_result;
                                        mont_start <= 1'b1;
                                        mont_a     <= mont_result;
                                        if (e_q[idx]) begin
                                            mont_b <= xm_q;
                                            state  <= S_MUL;
                                        end else if (idx == '0) begin
                                            mont_b <= ONE;
                                            state  <= S_FROM;
                                        end else begin
                                            mont_b <= mont_result;
                                            idx    <= idx - 1'b1;
                                            state  <= S_SQ;
                                        end
                                    end
                                    S_MUL: begin
                                        a_q        <= mont_result;
                                        mont_start <= 1'b1;
                                        mont_a     <= mont_result;
                                        if (idx == '0) begin
                                            mont_b <= ONE;
                                            state  <= S_FROM;
                                        end else begin
                                            mont_b <= mont_result;
                                            idx    <= idx - 1'b1;
                                            state  <= S_SQ;
                                        end
                                    end
                                    default: begin
                                        a_q    <= mont_result;
                                        result <= mont_result;
                                        done   <= 1'b1;
                                        state  <= S_DONE;
                                    end
                                endcase
                            end
                        end
                    endcase
                end
            endcase
        end
    end

endmodule

// File: tb/tb_modexp_ctrl.sv
// Bench for modexp_ctrl with an 8-bit exponent: a behavioural montgomery responder,
// an operand scoreboard filled from a reference square-and-multiply model, and a vector table.
// Handles both builds of MODEXP_SKIP_LEADING_ZEROS_EN.
module tb_modexp_ctrl;

    localparam int EW = 8;

    logic            clk;
    logic            reset;
    logic            start;
    logic [1023:0]   in_x, in_m, in_r, in_r2;
    logic [EW-1:0]   in_e;
    logic [1023:0]   result;
    logic            done, busy, mont_start;
    logic [1023:0]   mont_a, mont_b, mont_m;
    logic [1023:0]   mont_result;
    logic            mont_done;

    modexp_ctrl #(.E_WIDTH(EW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_x(in_x), .in_e(in_e), .in_m(in_m), .in_r(in_r), .in_r2(in_r2),
        .result(result), .done(done), .busy(busy),
        .mont_start(mont_start), .mont_a(mont_a), .mont_b(mont_b), .mont_m(mont_m),
        .mont_result(mont_result), .mont_done(mont_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [1023:0] a;
        logic [1023:0] b;
    } op_t;

    typedef struct {
        longint        x;
        logic [EW-1:0] e;
        longint        m;
        longint        res;
        int            ops_plain;
        int            ops_skip;
    } vec_t;

    op_t    sbq[$];
    int     checks = 0;
    int     errors = 0;
    int     op_count = 0;
    int     done_cnt = 0;
    int     lat = 1;
    int     drop_delay = 1;
    longint m_cur = 13, r_mod = 1, rinv_mod = 1;

    task automatic chkv(input string nm, input logic [1023:0] got, input logic [1023:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got[63:0], exp[63:0]);
        end
    endtask

    task automatic chki(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", nm, got, exp);
        end
    endtask

    // Montgomery product a*b*R^-1 mod M for small moduli, R = 2^1024.
    function automatic longint mmul(input longint a, input longint b);
        return (((a * b) % m_cur) * rinv_mod) % m_cur;
    endfunction

    task automatic setup_mod(input longint m);
        m_cur = m;
        r_mod = 1;
        for (int k = 0; k < 1024; k++) r_mod = (r_mod * 2) % m;
        rinv_mod = 0;
        for (longint k = 1; k < m; k++) if (((k * r_mod) % m) == 1) rinv_mod = k;
    endtask

    task automatic push_op(input longint a, input longint b);
        op_t o;
        o.a = '0;
        o.b = '0;
        o.a[63:0] = a;
        o.b[63:0] = b;
        sbq.push_back(o);
    endtask

    // Reference sequence of operand pairs for one run.
    task automatic build(input longint x, input logic [EW-1:0] e);
        longint xm, a, r2;
        int     top;
        r2 = (r_mod * r_mod) % m_cur;
        push_op(x, r2);
        xm = mmul(x, r2);
        a  = r_mod;
        top = EW - 1;
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
        top = -1;
        for (int k = 0; k < EW; k++) if (e[k]) top = k;
`endif
        for (int i = top; i >= 0; i--) begin
            push_op(a, a);
            a = mmul(a, a);
            if (e[i]) begin
                push_op(a, xm);
                a = mmul(a, xm);
            end
        end
        push_op(a, 1);
    endtask

    // Behavioural montgomery: drops done drop_delay cycles after a start, raises it lat cycles later, holds it high.
    initial begin : responder
        int     cnt;
        bit     pending;
        longint pres;
        op_t    eo;
        mont_done   = 1'b0;
        mont_result = '0;
        pending     = 1'b0;
        cnt         = 0;
        pres        = 0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                pending   = 1'b0;
                mont_done = 1'b0;
            end else if (mont_start) begin
                chk1("op_overlap", pending, 1'b0);
                op_count++;
                chki("sb_has_entry", (sbq.size() > 0) ? 1 : 0, 1);
                if (sbq.size() > 0) begin
                    eo = sbq.pop_front();
                    chkv("mont_a", mont_a, eo.a);
                    chkv("mont_b", mont_b, eo.b);
                end
                chkv("mont_m", mont_m, 1024'(m_cur));
                pres    = mmul(longint'(mont_a[31:0]), longint'(mont_b[31:0]));
                pending = 1'b1;
                cnt     = 0;
            end else if (pending) begin
                cnt++;
                if (cnt == drop_delay) mont_done = 1'b0;
                if (cnt == drop_delay + lat) begin
                    mont_done   = 1'b1;
                    mont_result = 1024'(pres);
                    pending     = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) if (done) done_cnt++;

    task automatic drive_start(input vec_t v);
        @(negedge clk);
        in_x  = 1024'(v.x);
        in_e  = v.e;
        in_m  = 1024'(v.m);
        in_r  = 1024'(r_mod);
        in_r2 = 1024'((r_mod * r_mod) % v.m);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_case(input string nm, input vec_t v, input int poke);
        int cyc;
        int exp_ops;
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
        exp_ops = v.ops_skip;
`else
        exp_ops = v.ops_plain;
`endif
        setup_mod(v.m);
        sbq.delete();
        build(v.x, v.e);
        op_count = 0;
        done_cnt = 0;
        drive_start(v);
        chk1({nm, "_busy_k1"}, busy, 1'b1);
        chk1({nm, "_mstart_k1"}, mont_start, 1'b1);
        cyc = 0;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (cyc == poke) begin
                start = 1'b1;
                in_x  = 1024'd4;
                in_e  = ~v.e;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk1({nm, "_done_seen"}, done, 1'b1);
        chkv({nm, "_result"}, result, 1024'(v.res));
        chk1({nm, "_busy_in_done"}, busy, 1'b1);
        @(negedge clk);
        chk1({nm, "_busy_after"}, busy, 1'b0);
        chk1({nm, "_done_1cyc"}, done, 1'b0);
        repeat (3) @(negedge clk);
        chki({nm, "_done_pulses"}, done_cnt, 1);
        chki({nm, "_op_count"}, op_count, exp_ops);
        chki({nm, "_sb_left"}, sbq.size(), 0);
        chkv({nm, "_result_held"}, result, 1024'(v.res));
    endtask

    vec_t tbl[7];

    initial begin
        int cyc;
        tbl[0] = '{x: 2,  e: 8'h0A, m: 13, res: 10, ops_plain: 12, ops_skip: 8};
        tbl[1] = '{x: 5,  e: 8'h00, m: 13, res: 1,  ops_plain: 10, ops_skip: 2};
        tbl[2] = '{x: 3,  e: 8'h05, m: 13, res: 9,  ops_plain: 12, ops_skip: 7};
        tbl[3] = '{x: 7,  e: 8'hFF, m: 13, res: 5,  ops_plain: 18, ops_skip: 18};
        tbl[4] = '{x: 1,  e: 8'h80, m: 13, res: 1,  ops_plain: 11, ops_skip: 11};
        tbl[5] = '{x: 12, e: 8'h01, m: 13, res: 12, ops_plain: 11, ops_skip: 4};
        tbl[6] = '{x: 4,  e: 8'h03, m: 11, res: 9,  ops_plain: 12, ops_skip: 6};

        reset = 1'b1;
        start = 1'b0;
        in_x  = '0;
        in_e  = '0;
        in_m  = '0;
        in_r  = '0;
        in_r2 = '0;
        repeat (3) @(negedge clk);
        chkv("rst_result", result, '0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_mstart", mont_start, 1'b0);
        chkv("rst_mont_a", mont_a, '0);
        chkv("rst_mont_b", mont_b, '0);
        chkv("rst_mont_m", mont_m, '0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            lat = 1 + (i % 3);
            drop_delay = 1;
            run_case($sformatf("vec%0d", i), tbl[i], 0);
        end

        // Stale done level held across the start and the first issue cycles.
        lat = 2;
        drop_delay = 3;
        @(negedge clk);
        mont_done   = 1'b1;
        mont_result = 1024'd5;
        run_case("stale", tbl[0], 0);
        drop_delay = 1;

        // Start pulsed while busy, with different operands on the inputs.
        lat = 1;
        run_case("poke", tbl[2], 6);

        // Reset during the third op's wait for done.
        lat = 4;
        setup_mod(13);
        sbq.delete();
        build(2, 8'h0A);
        op_count = 0;
        drive_start(tbl[0]);
        cyc = 0;
        while (op_count < 3 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        chki("rst_mid_third_op", op_count, 3);
        repeat (2) @(negedge clk);
        chk1("rst_mid_busy_before", busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        chk1("rst_mid_busy", busy, 1'b0);
        chk1("rst_mid_done", done, 1'b0);
        chkv("rst_mid_result", result, '0);
        chk1("rst_mid_mstart", mont_start, 1'b0);
        reset = 1'b0;
        lat = 2;
        run_case("after_rst", tbl[2], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
